seq_divider: RTL and testbench

//  Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor -> 16-bit quotient, 8-bit remainder.

---
 rtl/mult_div_pkg.sv | 11 +
 rtl/seq_divider_div_step.sv | 20 ++
 rtl/seq_divider.sv | 86 ++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared constants for the sequential multiply/divide datapaths: FSM encodings,
// step count and operand widths.
package mult_div_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DIV_STEPS = 16;
  localparam int OPA_W     = 16;
  localparam int OPB_W     = 8;
endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; no state and no backpressure.
module div_step
  import mult_div_pkg::*;
(
  input  logic [OPB_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [OPB_W-1:0] dsr,
  output logic [OPB_W-1:0] rem_out,
  output logic             qbit
);
  logic [OPB_W:0] t;

  always_comb begin
    t = {rem_in, bit_in};
    qbit = (t >= {1'b0, dsr});
    // rem_in < dsr keeps the difference within OPB_W bits.
    rem_out = qbit ? OPB_W'(t - {1'b0, dsr}) : t[OPB_W-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// 16/8 unsigned restoring divider, one quotient bit per clock; done 17 edges after start.
// start ignored outside IDLE; SEQ_DIV_ZERO_FAST_EN finishes divide-by-zero in one edge.
module seq_divider
  import mult_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPA_W-1:0] dividend,
  input  logic [OPB_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [OPA_W-1:0] quotient,
  output logic [OPB_W-1:0] remainder,
  output logic             div_zero
);
  logic [1:0]       state;
  logic [OPA_W-1:0] dvd_q;
  logic [OPB_W-1:0] dsr;
  logic [OPB_W-1:0] rem;
  logic [4:0]       cnt;
  logic [OPB_W-1:0] step_rem;
  logic             step_qbit;

  div_step u_step (
    .rem_in  (rem),
    .bit_in  (dvd_q[OPA_W-1]),
    .dsr     (dsr),
    .rem_out (step_rem),
    .qbit    (step_qbit)
  );

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dvd_q     <= '0;
      dsr       <= '0;
      rem       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dvd_q    <= dividend;
            dsr      <= divisor;
            rem      <= '0;
            cnt      <= '0;
            div_zero <= (divisor == '0);
`ifdef SEQ_DIV_ZERO_FAST_EN
            // Preload the known divide-by-zero result so DONE publishes it as usual.
            if (divisor == '0) begin
              dvd_q <= '1;
              rem   <= dividend[OPB_W-1:0];
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
`else
            state <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          rem   <= step_rem;
          dvd_q <= {dvd_q[OPA_W-2:0], step_qbit};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'(DIV_STEPS - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          quotient  <= dvd_q;
          remainder <= rem;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, corner sequences, random back-to-back run.
module tb_seq_divider;
  logic        clk, rst_n, start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int checks = 0;
  int failures = 0;

`ifdef SEQ_DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 17;
`endif

  seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic, with the defined divide-by-zero result.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r);
    if (b == 0) begin
      q = 16'hFFFF;
      r = a[7:0];
    end else begin
      q = a / 16'(b);
      r = 8'(a % 16'(b));
    end
  endfunction

  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic z, output int lat);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q = quotient; r = remainder; z = div_zero;
  endtask

  initial begin
    vec_t        tbl[8];
    logic [15:0] q, mq, last_q;
    logic [7:0]  r, mr, last_r;
    logic        z;
    int          lat, ndone, cyc, last_cyc, wait_cyc;
    logic        stable;
    logic [15:0] cur_a;
    logic [7:0]  cur_b;

    tbl[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
    tbl[1] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,   1'b0};
    tbl[2] = '{16'd5,     8'd9,   16'd0,     8'd5,   1'b0};
    tbl[3] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1};
    tbl[4] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b0};
    tbl[5] = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0};
    tbl[6] = '{16'd255,   8'd16,  16'd15,    8'd15,  1'b0};
    tbl[7] = '{16'd50000, 8'd200, 16'd250,   8'd0,   1'b0};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_quotient", 32'(quotient), 0);
    chk("reset_remainder", 32'(remainder), 0);
    chk("reset_div_zero", 32'(div_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_div(tbl[i].a, tbl[i].b, q, r, z, lat);
      chk($sformatf("tbl%0d_quotient", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("tbl%0d_remainder", i), 32'(r), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_div_zero", i), 32'(z), 32'(tbl[i].z));
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].z ? ZERO_LAT : 17));
      @(negedge clk);
      chk($sformatf("tbl%0d_done_single", i), 32'(done), 0);
      chk($sformatf("tbl%0d_hold", i), 32'({quotient, remainder}), 32'({tbl[i].q, tbl[i].r}));
    end

    // New operands pulsed mid-run must be ignored.
    @(negedge clk);
    dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_busy", 32'(busy), 1);
    dividend = 16'hFFFF; divisor = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("midrun_quotient", 32'(quotient), 32'd142);
        chk("midrun_remainder", 32'(remainder), 32'd6);
      end
    end
    chk("midrun_done_count", 32'(ndone), 1);

    // Reset asserted partway through a divide aborts it.
    @(negedge clk);
    dividend = 16'd4321; divisor = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 0);
    run_div(16'd4321, 8'd13, q, r, z, lat);
    chk("fresh_quotient", 32'(q), 32'd332);
    chk("fresh_remainder", 32'(r), 32'd5);
    chk("fresh_latency", 32'(lat), 32'd17);

    // Random back-to-back with start held high.
    @(negedge clk);
    cur_a = 16'($urandom); cur_b = 8'($urandom_range(1, 255));
    dividend = cur_a; divisor = cur_b; start = 1'b1;
    cyc = 0; last_cyc = 0; last_q = '0; last_r = '0;
    for (int n = 0; n < 400; n++) begin
      stable = 1'b1;
      wait_cyc = 0;
      do begin
        @(negedge clk);
        cyc++; wait_cyc++;
        if (!done && n > 0 && (quotient !== last_q || remainder !== last_r)) stable = 1'b0;
      end while (!done && wait_cyc < 40);
      model(cur_a, cur_b, mq, mr);
      chk("rand_done_seen", 32'(done), 1);
      chk("rand_result", 32'({quotient, remainder}), 32'({mq, mr}));
      chk("rand_invariant", 32'(quotient) * 32'(cur_b) + 32'(remainder), 32'(cur_a));
      chk("rand_rem_lt_div", 32'(remainder < cur_b), 1);
      if (n > 0) begin
        chk("rand_spacing", 32'(cyc - last_cyc), 32'd18);
        chk("rand_stable", 32'(stable), 1);
      end
      last_cyc = cyc; last_q = mq; last_r = mr;
      cur_a = 16'($urandom); cur_b = 8'($urandom_range(1, 255));
      dividend = cur_a; divisor = cur_b;
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
